// File: rtl/controle_medicao_hcsr04.sv
`default_nettype none
// ============================================================================
// controle_medicao_hcsr04 : periodic measurement scheduler for interface_hcsr04
// Revision 1.0
// ============================================================================
module controle_medicao_hcsr04 #(
    parameter int          INTERVALO  = 50_000_000,
    parameter int          TIMEOUT    = 3_500_000,
    parameter int          MAX_FALHAS = 3,
    parameter logic [11:0] LIMIAR     = 12'h020
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic        pronto,
    input  logic [11:0] medida,
    output logic        medir,
    output logic [11:0] medida_valida,
    output logic        nova_medida,
    output logic        erro,
    output logic        alarme,
    output logic [3:0]  db_estado
);

    localparam int IW = $clog2(INTERVALO);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [IW-1:0] FIM_INTERVALO = IW'(INTERVALO - 2);
    localparam logic [TW-1:0] FIM_TIMEOUT   = TW'(TIMEOUT - 1);
    localparam logic [3:0]    LIMITE_FALHAS = 4'(MAX_FALHAS);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        ESPERA   = 4'd1,
        DISPARA  = 4'd2,
        AGUARDA  = 4'd3,
        ARMAZENA = 4'd4,
        FALHA    = 4'd5
    } estado_t;

    estado_t       estado;
    estado_t       proximo;
    logic [IW-1:0] intervalo;
    logic [TW-1:0] tempo;
    logic [3:0]    falhas;
    logic [3:0]    falhas_prox;

    assign falhas_prox = (falhas == 4'hF) ? 4'hF : falhas + 4'd1;
    assign db_estado   = estado;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo     = estado;
        medir       = 1'b0;
        nova_medida = 1'b0;
        case (estado)
            INICIAL: begin
                if (ligar) proximo = DISPARA;
            end
            ESPERA: begin
                if (!ligar) begin
                    proximo = INICIAL;
                end else if (intervalo == FIM_INTERVALO) begin
                    proximo = DISPARA;
                end
            end
            DISPARA: begin
                medir   = 1'b1;
                proximo = AGUARDA;
            end
            AGUARDA: begin
                // a response arriving on the expiry cycle still counts
                if (pronto) begin
                    proximo = ARMAZENA;
                end else if (tempo == FIM_TIMEOUT) begin
                    proximo = FALHA;
                end
            end
            ARMAZENA: begin
                nova_medida = 1'b1;
                proximo     = ESPERA;
            end
            FALHA: begin
                proximo = ESPERA;
            end
            default: begin
                proximo = INICIAL;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            intervalo     <= '0;
            tempo         <= '0;
            falhas        <= 4'd0;
            medida_valida <= 12'h000;
            erro          <= 1'b0;
            alarme        <= 1'b0;
        end else begin
            if (estado == DISPARA) begin
                intervalo <= '0;
                tempo     <= '0;
            end else begin
                if (intervalo != FIM_INTERVALO) intervalo <= intervalo + IW'(1);
                if (estado == AGUARDA)          tempo     <= tempo + TW'(1);
            end
            if (estado == AGUARDA && pronto) medida_valida <= medida;
            if (estado == ARMAZENA) begin
                falhas <= 4'd0;
                erro   <= 1'b0;
                // BCD digits order the same way as binary, so a plain compare works
                alarme <= (medida_valida < LIMIAR);
            end
            if (estado == FALHA) begin
                falhas <= falhas_prox;
                if (falhas_prox >= LIMITE_FALHAS) erro <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_controle_medicao_hcsr04.sv
`default_nettype none
// ============================================================================
// tb_controle_medicao_hcsr04 : scoreboard bench for the measurement scheduler
// Revision 1.0
// ============================================================================
module tb_controle_medicao_hcsr04;

    localparam int          INTERVALO  = 1000;
    localparam int          TIMEOUT    = 400;
    localparam int          MAX_FALHAS = 3;
    localparam int          LIMIAR_CM  = 20;
    localparam int          N_LATE     = 20;

    typedef struct {
        int          kind;   // 0 medir, 1 nova_medida, 2 falha
        int          cyc;
        logic [11:0] mv;
        logic        al;
        logic        er;
    } ev_t;

    typedef struct {
        int          n;      // 0 = responder stays silent
        logic [11:0] v;
    } resp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ligar = 1'b0;
    logic        pronto = 1'b0;
    logic [11:0] medida = 12'h000;
    logic        medir, nova_medida, erro, alarme;
    logic [11:0] medida_valida;
    logic [3:0]  db_estado;

    logic        reset_b = 1'b0;
    logic        ligar_b = 1'b0;
    logic        pronto_b = 1'b0;
    logic        medir_b, nova_b, erro_b, alarme_b;
    logic [11:0] mv_b;
    logic [3:0]  est_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ev_t   exp_q[$];
    resp_t resp_q[$];

    // model state carried across segments
    logic [11:0] m_mv = 12'h000;
    logic        m_al = 1'b0;
    logic        m_er = 1'b0;
    int          m_falhas = 0;

    controle_medicao_hcsr04 #(
        .INTERVALO(INTERVALO), .TIMEOUT(TIMEOUT), .MAX_FALHAS(MAX_FALHAS), .LIMIAR(12'h020)
    ) dut (
        .clock(clock), .reset(reset), .ligar(ligar), .pronto(pronto), .medida(medida),
        .medir(medir), .medida_valida(medida_valida), .nova_medida(nova_medida),
        .erro(erro), .alarme(alarme), .db_estado(db_estado)
    );

    // short interval instance: responses finish after the nominal restart
    controle_medicao_hcsr04 #(
        .INTERVALO(16), .TIMEOUT(TIMEOUT), .MAX_FALHAS(MAX_FALHAS), .LIMIAR(12'h020)
    ) dut_b (
        .clock(clock), .reset(reset_b), .ligar(ligar_b), .pronto(pronto_b), .medida(12'h050),
        .medir(medir_b), .medida_valida(mv_b), .nova_medida(nova_b),
        .erro(erro_b), .alarme(alarme_b), .db_estado(est_b)
    );

    always #10 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int bcd2int(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [11:0] rand_bcd();
        logic [11:0] r;
        case ($urandom_range(0, 3))
            0:       r = 12'h019;
            1:       r = 12'h020;
            2:       r = {4'h0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            default: r = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        endcase
        return r;
    endfunction

    // Predicts every observable event of one ligar-high session from the response plan.
    task automatic run_segment(input resp_t plan[$]);
        int k, t, t_end, last_t;
        ev_t e;
        @(negedge clock);
        k = cyc;
        ligar = 1'b1;
        t = k + 1;
        last_t = t;
        foreach (plan[i]) begin
            resp_q.push_back(plan[i]);
            e = '{kind: 0, cyc: t, mv: m_mv, al: m_al, er: m_er};
            exp_q.push_back(e);
            if (plan[i].n >= 1 && plan[i].n <= TIMEOUT) begin
                t_end    = t + plan[i].n + 1;
                m_mv     = plan[i].v;
                m_al     = (bcd2int(plan[i].v) < LIMIAR_CM);
                m_er     = 1'b0;
                m_falhas = 0;
                e = '{kind: 1, cyc: t_end, mv: m_mv, al: m_al, er: m_er};
            end else begin
                t_end = t + TIMEOUT + 1;
                if (m_falhas < 15) m_falhas = m_falhas + 1;
                if (m_falhas >= MAX_FALHAS) m_er = 1'b1;
                e = '{kind: 2, cyc: t_end, mv: m_mv, al: m_al, er: m_er};
            end
            exp_q.push_back(e);
            last_t = t;
            t = (t + INTERVALO > t_end + 2) ? t + INTERVALO : t_end + 2;
        end
        while (cyc < last_t + 1) @(negedge clock);
        ligar = 1'b0;
        while (cyc < last_t + INTERVALO + 20) @(negedge clock);
        chk("events drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    function automatic resp_t rand_resp();
        resp_t r;
        r.n = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
        r.v = rand_bcd();
        return r;
    endfunction

    // responder: answers each medir after the planned delay, then injects a stray pronto
    initial forever begin
        resp_t r;
        @(negedge clock);
        if (medir && reset) begin
            if (resp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL responder: medir with no planned response at cycle %0d", cyc);
            end else begin
                r = resp_q.pop_front();
                if (r.n > 0) begin
                    repeat (r.n) @(negedge clock);
                    pronto = 1'b1;
                    medida = r.v;
                    @(negedge clock);
                    pronto = 1'b0;
                    medida = 12'h999;
                    repeat (8) @(negedge clock);
                    pronto = 1'b1;
                    @(negedge clock);
                    pronto = 1'b0;
                end
            end
        end
    end

    // monitor: pops the scoreboard whenever the DUT shows an event
    initial begin
        bit   post = 1'b0;
        ev_t  pe;
        ev_t  e;
        int   kind;
        forever begin
            @(negedge clock);
            if (post) begin
                chk("alarme after event", int'(alarme), int'(pe.al));
                chk("erro after event", int'(erro), int'(pe.er));
                post = 1'b0;
            end
            if (medir || nova_medida || db_estado == 4'd5) begin
                kind = medir ? 0 : (nova_medida ? 1 : 2);
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected event: kind %0d at cycle %0d, none expected", kind, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("event kind", kind, e.kind);
                    chk("event cycle", cyc, e.cyc);
                    if (kind == 0) begin
                        chk("db_estado at medir", int'(db_estado), 2);
                    end else begin
                        chk("medida_valida", int'(medida_valida), int'(e.mv));
                        pe = e;
                        post = 1'b1;
                    end
                end
            end
        end
    end

    // late-completion instance: period becomes N+3 (ARMAZENA, one ESPERA, DISPARA)
    initial begin
        int prev, t;
        bit got;
        repeat (3) @(negedge clock);
        reset_b = 1'b1;
        ligar_b = 1'b1;
        prev = -1;
        for (int i = 0; i < 5; i++) begin
            got = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clock);
                if (medir_b) got = 1'b1;
            end
            chk("late medir seen", int'(got), 1);
            t = cyc;
            if (prev >= 0) chk("late period", t - prev, N_LATE + 3);
            prev = t;
            repeat (N_LATE) @(negedge clock);
            pronto_b = 1'b1;
            @(negedge clock);
            pronto_b = 1'b0;
            chk("late nova_medida", int'(nova_b), 1);
            chk("late medida_valida", int'(mv_b), 12'h050);
        end
        ligar_b = 1'b0;
    end

    initial begin
        #(20 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resp_t plan[$];
        int    k;
        #1;
        chk("reset medir", int'(medir), 0);
        chk("reset nova_medida", int'(nova_medida), 0);
        chk("reset erro", int'(erro), 0);
        chk("reset alarme", int'(alarme), 0);
        chk("reset medida_valida", int'(medida_valida), 0);
        chk("reset db_estado", int'(db_estado), 0);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        // directed: threshold boundary, three timeouts, expiry-cycle response
        plan = '{'{100, 12'h100}, '{100, 12'h019}, '{100, 12'h020},
                 '{0, 12'h000}, '{0, 12'h000}, '{0, 12'h000},
                 '{TIMEOUT, 12'h345}, '{0, 12'h000}, '{37, 12'h007}};
        run_segment(plan);

        for (int s = 0; s < 2; s++) begin
            plan.delete();
            for (int i = 0; i < 8; i++) plan.push_back(rand_resp());
            run_segment(plan);
        end

        // reset in the middle of a wait; the late pronto must be ignored
        @(negedge clock);
        k = cyc;
        ligar = 1'b1;
        resp_q.push_back('{200, 12'h123});
        exp_q.push_back('{kind: 0, cyc: k + 1, mv: m_mv, al: m_al, er: m_er});
        while (cyc < k + 51) @(negedge clock);
        reset = 1'b0;
        ligar = 1'b0;
        #1;
        chk("midreset medir", int'(medir), 0);
        chk("midreset nova_medida", int'(nova_medida), 0);
        chk("midreset erro", int'(erro), 0);
        chk("midreset alarme", int'(alarme), 0);
        chk("midreset medida_valida", int'(medida_valida), 0);
        chk("midreset db_estado", int'(db_estado), 0);
        m_mv = 12'h000;
        m_al = 1'b0;
        m_er = 1'b0;
        m_falhas = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        while (cyc < k + 400) @(negedge clock);
        chk("midreset events drained", exp_q.size(), 0);
        exp_q.delete();

        plan.delete();
        for (int i = 0; i < 6; i++) plan.push_back(rand_resp());
        run_segment(plan);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
